// File: rtl/jtcps1_obj_pkg.sv
// Shared constants and attribute decoding for the CPS1 object line-table builder.
package jtcps1_obj_pkg;

    localparam int MAXOBJ = 112;

    // Word slots inside one line-table entry
    localparam logic [1:0] ATTR = 2'd0;
    localparam logic [1:0] CODE = 2'd1;
    localparam logic [1:0] XPOS = 2'd2;

    localparam logic [7:0]  END_MARK  = 8'hFF;
    localparam logic [15:0] TERM_ATTR = 16'hFFFF;
    localparam logic [15:0] TERM_CODE = 16'hFFFF;
    localparam logic [15:0] TERM_XPOS = 16'h0000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_TEST = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_TERM = 3'd4;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] w;
        logic       vflip;
        logic       hflip;
        logic [4:0] pal;
    } obj_attr_t;

    function automatic obj_attr_t decode_attr(input logic [15:0] a);
        obj_attr_t d;
        d.h     = a[15:12];
        d.w     = a[11:8];
        d.vflip = a[6];
        d.hflip = a[5];
        d.pal   = a[4:0];
        return d;
    endfunction

endpackage

// File: rtl/jtcps1_obj_table_ram.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
module jtframe_dual_ram #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/jtcps1_obj_table.sv
// Builds the per-line sprite table: scans object RAM, emits one entry per visible
// tile column into the write bank while the draw stage reads the other bank.
module jtcps1_obj_table #(
    parameter int MAXOBJ = jtcps1_obj_pkg::MAXOBJ
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  vrender,
    output logic [9:0]  obj_addr,
    input  logic [15:0] obj_data,
    input  logic [8:0]  table_addr,
    output logic [15:0] table_data,
    output logic        done
);
    import jtcps1_obj_pkg::*;

    logic [2:0]  state;
    logic        rd_bank, rd_ok, last;
    logic [1:0]  bank_ok;
    logic [8:0]  vr, x, y;
    logic [15:0] code;
    logic [7:0]  n;
    logic [6:0]  ent;
    logic [1:0]  rcnt, wcnt;
    logic [3:0]  c, row, vsub;
    obj_attr_t   cur, nxt;

    logic [8:0]  dy, x_out;
    logic [9:0]  span;
    logic        visible, skip, full_next;
    logic [3:0]  col;
    logic [15:0] code_out, ram_din, ram_q;
    logic [9:0]  ram_addr;
    logic        ram_we;

    // During TEST obj_data already carries the attribute word of the current object
    assign nxt       = decode_attr(obj_data);
    assign dy        = vr - y;
    assign span      = {1'b0, ({1'b0, nxt.h} + 5'd1), 4'd0};
    assign visible   = {1'b0, dy} < span;
    assign col       = cur.hflip ? cur.w - c : c;
    assign x_out     = x + {1'b0, c, 4'd0};
    assign code_out  = {code[15:8], code[7:4] + row, code[3:0] + col};
    assign skip      = x_out == 9'd0;
    assign full_next = ({1'b0, ent} + 8'd1) == 8'(MAXOBJ);

    // A start during a scan seals the old bank with an x = 0 terminator in the same cycle
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = {~rd_bank, ent, wcnt};
        ram_din  = 16'h0000;
        if (start && state != ST_IDLE) begin
            ram_we   = 1'b1;
            ram_addr = {~rd_bank, ent, XPOS};
            ram_din  = TERM_XPOS;
        end else if (state == ST_EMIT) begin
            ram_we = !(wcnt == ATTR && skip);
            case (wcnt)
                ATTR:    ram_din = {4'h0, vsub, 1'b0, cur.vflip, cur.hflip, cur.pal};
                CODE:    ram_din = code_out;
                default: ram_din = {7'd0, x_out};
            endcase
        end else if (state == ST_TERM) begin
            ram_we = 1'b1;
            case (wcnt)
                ATTR:    ram_din = TERM_ATTR;
                CODE:    ram_din = TERM_CODE;
                default: ram_din = TERM_XPOS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rd_bank  <= 1'b0;
            bank_ok  <= 2'b00;
            done     <= 1'b0;
            obj_addr <= 10'd0;
            vr       <= 9'd0;
            x        <= 9'd0;
            y        <= 9'd0;
            code     <= 16'h0000;
            n        <= 8'd0;
            ent      <= 7'd0;
            rcnt     <= 2'd0;
            wcnt     <= 2'd0;
            c        <= 4'd0;
            row      <= 4'd0;
            vsub     <= 4'd0;
            last     <= 1'b0;
            cur      <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                if (state != ST_IDLE) bank_ok[~rd_bank] <= 1'b1;
                rd_bank  <= ~rd_bank;
                vr       <= vrender;
                n        <= 8'd0;
                ent      <= 7'd0;
                obj_addr <= 10'd0;
                rcnt     <= 2'd0;
                wcnt     <= 2'd0;
                state    <= ST_READ;
            end else begin
                case (state)
                    // Address runs one word ahead; w3 is consumed straight from obj_data in TEST
                    ST_READ: begin
                        if (rcnt != 2'd3) obj_addr[1:0] <= rcnt + 2'd1;
                        case (rcnt)
                            2'd1:    x    <= obj_data[8:0];
                            2'd2:    y    <= obj_data[8:0];
                            2'd3:    code <= obj_data;
                            default: ;
                        endcase
                        if (rcnt == 2'd3) state <= ST_TEST;
                        rcnt <= rcnt + 2'd1;
                    end
                    ST_TEST: begin
                        cur      <= nxt;
                        row      <= nxt.vflip ? nxt.h - dy[7:4] : dy[7:4];
                        vsub     <= nxt.vflip ? ~dy[3:0] : dy[3:0];
                        last     <= n == 8'hFF;
                        c        <= 4'd0;
                        wcnt     <= 2'd0;
                        rcnt     <= 2'd0;
                        n        <= n + 8'd1;
                        obj_addr <= {n + 8'd1, 2'b00};
                        if (obj_data[15:8] == END_MARK) state <= ST_TERM;
                        else if (visible)               state <= ST_EMIT;
                        else if (n == 8'hFF)            state <= ST_TERM;
                        else                            state <= ST_READ;
                    end
                    ST_EMIT: begin
                        if ((wcnt == ATTR && skip) || wcnt == XPOS) begin
                            wcnt <= 2'd0;
                            if (wcnt == XPOS) ent <= ent + 7'd1;
                            if (wcnt == XPOS && full_next) state <= ST_TERM;
                            else if (c == cur.w)           state <= last ? ST_TERM : ST_READ;
                            else                           c <= c + 4'd1;
                        end else begin
                            wcnt <= wcnt + 2'd1;
                        end
                    end
                    ST_TERM: begin
                        if (wcnt == XPOS) begin
                            wcnt              <= 2'd0;
                            done              <= 1'b1;
                            bank_ok[~rd_bank] <= 1'b1;
                            state             <= ST_IDLE;
                        end else begin
                            wcnt <= wcnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reads of a bank that never saw a terminator are masked to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ok <= 1'b0;
        else        rd_ok <= bank_ok[rd_bank];
    end

    assign table_data = rd_ok ? ram_q : 16'h0000;

    jtframe_dual_ram #(.DW(16), .AW(10)) u_ram (
        .clk    (clk),
        .addr_a (ram_addr),
        .data_a (ram_din),
        .we_a   (ram_we),
        .addr_b ({rd_bank, table_addr}),
        .q_b    (ram_q)
    );

endmodule

// File: tb/tb_jtcps1_obj_table.sv
// Directed bench for the object line-table builder with a behavioural object RAM.
module tb_jtcps1_obj_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  vrender = 9'd0;
    logic [8:0]  table_addr = 9'd0;
    logic [9:0]  obj_addr;
    logic [15:0] obj_data;
    logic [15:0] table_data;
    logic        done;
    logic [15:0] objram [0:1023];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) obj_data <= objram[obj_addr];

    jtcps1_obj_table #(.MAXOBJ(112)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vrender    (vrender),
        .obj_addr   (obj_addr),
        .obj_data   (obj_data),
        .table_addr (table_addr),
        .table_data (table_data),
        .done       (done)
    );

    task automatic clear_objs;
        for (int i = 0; i < 1024; i++) objram[i] = (i % 4 == 3) ? 16'hFF00 : 16'h0000;
    endtask

    task automatic set_obj(input int idx, input logic [8:0] px, input logic [8:0] py,
                           input logic [15:0] pcode, input logic [15:0] pattr);
        objram[idx*4]   = {7'd0, px};
        objram[idx*4+1] = {7'd0, py};
        objram[idx*4+2] = pcode;
        objram[idx*4+3] = pattr;
    endtask

    task automatic pulse_start(input logic [8:0] vr);
        @(negedge clk);
        vrender = vr;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    task automatic read_tbl(input int e, input int wd, output logic [15:0] v);
        @(negedge clk);
        table_addr = {7'(e), 2'(wd)};
        @(posedge clk);
        #1 v = table_data;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        int p;
        int el[4];
        el = '{0, 5, 77, 127};
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++;
        if (obj_addr !== 10'd0) begin errors++; $display("FAIL reset_obj_addr got %h expected 000", obj_addr); end
        checks++;
        if (table_data !== 16'h0000) begin errors++; $display("FAIL reset_table_data got %h expected 0000", table_data); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_tbl(el[i], i % 3, v);
            checks++;
            if (v !== 16'h0000) begin errors++; $display("FAIL reset_bank0 e%0d got %h expected 0000", el[i], v); end
        end
        clear_objs();
        pulse_start(9'd0);
        count_done(50, p);
        checks++;
        if (p != 1) begin errors++; $display("FAIL reset_empty_done got %0d pulses expected 1", p); end
        for (int i = 0; i < 4; i++) begin
            read_tbl(el[i], 0, v);
            checks++;
            if (v !== 16'h0000) begin errors++; $display("FAIL reset_bank1 e%0d got %h expected 0000", el[i], v); end
        end
    endtask

    task automatic test_single;
        logic [15:0] v;
        int p;
        int el[5];
        int wl[5];
        logic [15:0] xl[5];
        clear_objs();
        set_obj(0, 9'd100, 9'd50, 16'h1230, 16'h0003);
        pulse_start(9'd55);
        count_done(100, p);
        checks++;
        if (p != 1) begin errors++; $display("FAIL single_done got %0d pulses expected 1", p); end
        pulse_start(9'd55);
        el = '{0, 0, 0, 1, 1};
        wl = '{0, 1, 2, 0, 2};
        xl = '{16'h0503, 16'h1230, 16'd100, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            read_tbl(el[i], wl[i], v);
            checks++;
            if (v !== xl[i]) begin errors++; $display("FAIL single e%0d w%0d got %h expected %h", el[i], wl[i], v, xl[i]); end
        end
    endtask

    task automatic test_flip;
        logic [15:0] v;
        int p;
        int el[10];
        int wl[10];
        logic [15:0] xl[10];
        clear_objs();
        set_obj(0, 9'd40, 9'd0, 16'h5670, 16'h1265);
        pulse_start(9'd20);
        count_done(100, p);
        checks++;
        if (p != 1) begin errors++; $display("FAIL flip_done got %0d pulses expected 1", p); end
        pulse_start(9'd20);
        el = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3};
        wl = '{0, 1, 2, 0, 1, 2, 1, 2, 0, 2};
        xl = '{16'h0B65, 16'h5672, 16'd40, 16'h0B65, 16'h5671, 16'd56, 16'h5670, 16'd72, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 10; i++) begin
            read_tbl(el[i], wl[i], v);
            checks++;
            if (v !== xl[i]) begin errors++; $display("FAIL flip e%0d w%0d got %h expected %h", el[i], wl[i], v, xl[i]); end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] v;
        int p;
        int el[4];
        int wl[4];
        logic [15:0] xl[4];
        logic [8:0] vrs[3];
        vrs = '{9'd4, 9'd40, 9'd0};
        el = '{0, 0, 1, 1};
        for (int t = 0; t < 3; t++) begin
            clear_objs();
            case (t)
                0: begin
                    set_obj(0, 9'd10, 9'd500, 16'h2000, 16'h1000);
                    wl = '{1, 2, 0, 2};
                    xl = '{16'h2010, 16'd10, 16'hFFFF, 16'h0000};
                end
                1: begin
                    set_obj(0, 9'd10, 9'd500, 16'h2000, 16'h1000);
                    el = '{0, 0, 0, 0};
                    wl = '{0, 1, 2, 2};
                    xl = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
                end
                default: begin
                    set_obj(0, 9'd496, 9'd0, 16'h3000, 16'h0100);
                    el = '{0, 0, 1, 1};
                    wl = '{1, 2, 0, 2};
                    xl = '{16'h3000, 16'd496, 16'hFFFF, 16'h0000};
                end
            endcase
            pulse_start(vrs[t]);
            count_done(100, p);
            checks++;
            if (p != 1) begin errors++; $display("FAIL wrap%0d_done got %0d pulses expected 1", t, p); end
            pulse_start(vrs[t]);
            for (int i = 0; i < 4; i++) begin
                read_tbl(el[i], wl[i], v);
                checks++;
                if (v !== xl[i]) begin errors++; $display("FAIL wrap%0d e%0d w%0d got %h expected %h", t, el[i], wl[i], v, xl[i]); end
            end
        end
    endtask

    task automatic test_full;
        logic [15:0] v;
        int p;
        int el[7];
        int wl[7];
        logic [15:0] xl[7];
        clear_objs();
        for (int i = 0; i < 200; i++) set_obj(i, 9'(i + 1), 9'd0, 16'(i), 16'h0000);
        pulse_start(9'd0);
        count_done(1700, p);
        checks++;
        if (p != 1) begin errors++; $display("FAIL full_done got %0d pulses expected 1", p); end
        pulse_start(9'd0);
        el = '{0, 50, 50, 111, 111, 112, 112};
        wl = '{2, 1, 2, 1, 2, 0, 2};
        xl = '{16'd1, 16'h0032, 16'd51, 16'h006F, 16'd112, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 7; i++) begin
            read_tbl(el[i], wl[i], v);
            checks++;
            if (v !== xl[i]) begin errors++; $display("FAIL full e%0d w%0d got %h expected %h", el[i], wl[i], v, xl[i]); end
        end
    endtask

    task automatic test_worst;
        logic [15:0] v;
        int p;
        int el[5];
        int wl[5];
        logic [15:0] xl[5];
        clear_objs();
        for (int i = 0; i < 144; i++) set_obj(i, 9'd1, 9'd100, 16'h0000, 16'h0000);
        for (int i = 144; i < 256; i++) set_obj(i, 9'(i - 143), 9'd0, 16'(i), 16'h0000);
        pulse_start(9'd0);
        count_done(1700, p);
        checks++;
        if (p != 1) begin errors++; $display("FAIL worst_done got %0d pulses expected 1", p); end
        pulse_start(9'd0);
        el = '{0, 0, 111, 112, 112};
        wl = '{1, 2, 1, 0, 2};
        xl = '{16'h0090, 16'd1, 16'h00FF, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            read_tbl(el[i], wl[i], v);
            checks++;
            if (v !== xl[i]) begin errors++; $display("FAIL worst e%0d w%0d got %h expected %h", el[i], wl[i], v, xl[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] v;
        int p;
        int el[4];
        int wl[4];
        logic [15:0] xl[4];
        clear_objs();
        for (int i = 0; i < 200; i++) set_obj(i, 9'(i + 1), 9'd0, 16'(i), 16'h0000);
        pulse_start(9'd0);
        count_done(1200, p);
        pulse_start(9'd0);
        count_done(1200, p);
        clear_objs();
        for (int i = 0; i < 10; i++) set_obj(i, 9'(i + 101), 9'd0, 16'(i), 16'h0000);
        for (int i = 10; i < 200; i++) set_obj(i, 9'd1, 9'd100, 16'h0000, 16'h0000);
        pulse_start(9'd0);
        count_done(300, p);
        checks++;
        if (p != 0) begin errors++; $display("FAIL abort_early_done got %0d pulses expected 0", p); end
        pulse_start(9'd0);
        el = '{9, 10, 0, 0};
        wl = '{2, 2, 2, 2};
        xl = '{16'd110, 16'h0000, 16'd101, 16'd101};
        for (int i = 0; i < 2; i++) begin
            read_tbl(el[i], wl[i], v);
            checks++;
            if (v !== xl[i]) begin errors++; $display("FAIL abort_old e%0d w%0d got %h expected %h", el[i], wl[i], v, xl[i]); end
        end
        count_done(1500, p);
        checks++;
        if (p != 1) begin errors++; $display("FAIL abort_new_done got %0d pulses expected 1", p); end
        pulse_start(9'd0);
        el = '{0, 9, 10, 10};
        wl = '{2, 2, 0, 2};
        xl = '{16'd101, 16'd110, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            read_tbl(el[i], wl[i], v);
            checks++;
            if (v !== xl[i]) begin errors++; $display("FAIL abort_new e%0d w%0d got %h expected %h", el[i], wl[i], v, xl[i]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] v;
        int p;
        pulse_start(9'd0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obj_addr !== 10'd0) begin errors++; $display("FAIL midreset_obj_addr got %h expected 000", obj_addr); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b expected 0", done); end
        rst_n = 1'b1;
        count_done(300, p);
        checks++;
        if (p != 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses expected 0", p); end
        checks++;
        if (obj_addr !== 10'd0) begin errors++; $display("FAIL midreset_idle_addr got %h expected 000", obj_addr); end
        read_tbl(0, 2, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL midreset_masked got %h expected 0000", v); end
        pulse_start(9'd0);
        count_done(1500, p);
        checks++;
        if (p != 1) begin errors++; $display("FAIL midreset_recover_done got %0d pulses expected 1", p); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_flip();
        test_wrap();
        test_full();
        test_worst();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtcps1_obj_table.md
JTCPS1_OBJ_TABLE -- requirements
Module: jtcps1_obj_table

Interface
REQ-001 Parameter MAXOBJ, default 112, maximum line-table entries per line; the draw stage's tile limit.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle pulse at line start; swaps banks and begins scanning.
REQ-005 vrender  input  9  line being prepared, sampled on start.
REQ-006 obj_addr  output  10  object RAM word address: {object[7:0], word[1:0]}.
REQ-007 obj_data  input  16  object RAM data, valid one cycle after obj_addr.
REQ-008 table_addr  input  9  draw-stage read address: {entry[6:0], word[1:0]}.
REQ-009 table_data  output  16  registered read data, one-cycle latency.
REQ-010 done  output  1  one-cycle pulse when the write bank is complete.

Function
REQ-011 Object words are w0 = x[8:0], w1 = y[8:0], w2 = code[15:0], w3 = attr: [15:12] tile rows-1 (H), [11:8] tile columns-1 (W), [6] vflip, [5] hflip, [4:0] palette.
REQ-012 Two table banks of 512 words; draw reads rd_bank; the block writes !rd_bank; rd_bank toggles on start.
REQ-013 FSM states: IDLE, READ (fetch w0..w3 of object n), TEST, EMIT (one entry per tile column), TERM, then back to IDLE.
REQ-014 Scanning runs over objects 0..255 in order and ends at the first object with attr[15:8] == 8'hFF, or after object 255.
REQ-015 Visibility: dy = (vrender - y) mod 512; visible iff dy < 16*(H+1) (10-bit compare).
REQ-016 Row: r = dy[7:4]; when vflip, r' = H - r, else r' = r; vsub = vflip ? ~dy[3:0] : dy[3:0].
REQ-017 For each column c = 0..W: col = hflip ? W-c : c; code_out = {code[15:8], code[7:4]+r', code[3:0]+col} with 4-bit nibble wraps; x_out = x + 16*c (9-bit wrap).
REQ-018 Entry words: word0 = {4'h0, vsub, 1'b0, vflip, hflip, pal}; word1 = code_out; word2 = x_out; word3 not written. Each entry takes 3 consecutive write cycles.
REQ-019 A tile with x_out == 0 is dropped without consuming an entry, because x == 0 is the terminator.
REQ-020 The table is full at MAXOBJ entries; further tiles and objects are ignored and the FSM goes to TERM.
REQ-021 TERM writes entry n: word0 = 16'hFFFF, word1 = 16'hFFFF, word2 = 16'h0000. It then pulses done for one cycle and returns to IDLE.
REQ-022 If start arrives while not IDLE: the terminator word2 = 0 is written at the current entry of the old write bank in that same cycle. Bank swap, vrender capture and the new scan then proceed; done is not pulsed for the aborted scan.
REQ-023 Throughput is at most 5 cycles per object plus 3 per emitted entry; the worst case (256 objects, 112 entries) completes in at most 1700 cycles.
REQ-024 Until a bank has received at least one terminator since reset, table_data reads from that bank return 16'h0000.

Reset
REQ-025 Asynchronous reset (rst_n low) sets FSM to IDLE, rd_bank = 0, done = 0, obj_addr = 0, table_data = 0, entry counter 0, and clears both bank-valid flags.
REQ-026 Reset asserted mid-scan abandons the scan immediately; no terminator is written.

Structure
REQ-027 The shared package jtcps1_obj_pkg holds MAXOBJ, the word-index constants (ATTR = 0, CODE = 1, XPOS = 2), the end marker 8'hFF and the terminator values.
REQ-028 The only sub-module is one dual-port RAM instance, jtframe_dual_ram (1024x16): port A for FSM writes, port B for draw reads with {rd_bank, table_addr}.

Verification
REQ-029 One object at x = 100, y = 50, code = 16'h1230, attr = 16'h0003, vrender = 55, then end marker: entry0 = {16'h0503, 16'h1230, 100}, entry1 word2 = 0, done pulses once.
REQ-030 attr H = 1, W = 2, hflip, vflip, y = 0, vrender = 20: three entries with codes …+{0x02, 0x01, 0x00} in row nibble 0, x = x, x+16, x+32, and vsub = 4'hB.
REQ-031 200 visible single-tile objects: exactly 112 entries written, terminator at entry 112, done pulses.
REQ-032 y = 500, vrender = 4 (wraps, dy = 16, H = 1): object visible with r = 1; y = 500, vrender = 40: not visible.
REQ-033 Second start 300 cycles into a scan: word2 = 0 at the current entry of the old bank, banks swap, and the new scan completes with exactly one done pulse.
REQ-034 Reset then read any address of bank 0 or bank 1 before the first start: table_data = 0; rst_n pulsed low mid-scan: FSM returns to IDLE and done stays low.
